adc_lane_align_ctrl: RTL and testbench

//  Link-training controller on the lclk side of one two-lane ADC deserializer channel.

---
 rtl/adc_lane_align_ctrl_if.sv | 30 +++
 rtl/adc_lane_align_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_adc_lane_align_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_lane_align_ctrl_if.sv
// Control/status bundle between the lane-align controller and one ADC deserializer channel.
interface adc_lane_align_ctrl_if;
   logic        start;
   logic [11:0] adc_bits;
   logic [1:0]  adc_io_reset;
   logic [1:0]  in_delay_reset;
   logic [1:0]  in_delay_data_ce;
   logic [1:0]  in_delay_data_inc;
   logic [1:0]  adc_bitslip;
   logic        busy;
   logic        locked;
   logic        fail;
   logic        fail_lane;
   logic [4:0]  tap_0;
   logic [4:0]  tap_1;

   // Controller side
   modport master (
      input  start, adc_bits,
      output adc_io_reset, in_delay_reset, in_delay_data_ce, in_delay_data_inc,
             adc_bitslip, busy, locked, fail, fail_lane, tap_0, tap_1
   );

   // Channel / readout side
   modport slave (
      output start, adc_bits,
      input  adc_io_reset, in_delay_reset, in_delay_data_ce, in_delay_data_inc,
             adc_bitslip, busy, locked, fail, fail_lane, tap_0, tap_1
   );
endinterface

// File: rtl/adc_lane_align_ctrl.sv
// Link-training controller for one two-lane ADC deserializer channel (lclk domain).
// Trains lane 0 then lane 1 by bitslip and input-delay stepping until each lane
// returns its slice of the training pattern for MATCH_LEN consecutive words.
module adc_lane_align_ctrl #(
   parameter logic [11:0] TRAIN_PATTERN = 12'hB38,
   parameter int unsigned MATCH_LEN     = 16,
   parameter int unsigned SETTLE        = 4,
   parameter int unsigned RESET_CYCLES  = 8,
   parameter int unsigned MAX_TAP       = 31
) (
   input  logic                        lclk,
   input  logic                        rst,
   adc_lane_align_ctrl_if.master       bus
);

   localparam int unsigned TAP_W         = 5;
   localparam int unsigned MATCH_W       = 8;
   localparam int unsigned CNT_W         = 4;
   localparam int unsigned SLIP_W        = 3;
   localparam int unsigned SLIPS_PER_TAP = 6;

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_SETTLE, S_CHECK, S_SLIP, S_STEP, S_LOCKED, S_FAIL
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [MATCH_W-1:0]   match_cnt, match_n;
   logic [SLIP_W-1:0]    slip_cnt, slip_n;
   logic                 lane, lane_n;
   logic [TAP_W-1:0]     tap_0, tap_0_n, tap_1, tap_1_n;
   logic [1:0]           io_reset, io_reset_n, dly_reset, dly_reset_n;
   logic [1:0]           ce, ce_n, bitslip, bitslip_n;
   logic                 busy, busy_n, locked, locked_n, fail, fail_n, fail_lane, fail_lane_n;
   logic [5:0]           lane_word, lane_pat;
   logic [TAP_W-1:0]     lane_tap;
   logic [1:0]           lane_mask;

   // State and registered outputs
   always_ff @(posedge lclk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         match_cnt <= '0;
         slip_cnt  <= '0;
         lane      <= 1'b0;
         tap_0     <= '0;
         tap_1     <= '0;
         io_reset  <= '0;
         dly_reset <= '0;
         ce        <= '0;
         bitslip   <= '0;
         busy      <= 1'b0;
         locked    <= 1'b0;
         fail      <= 1'b0;
         fail_lane <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         match_cnt <= match_n;
         slip_cnt  <= slip_n;
         lane      <= lane_n;
         tap_0     <= tap_0_n;
         tap_1     <= tap_1_n;
         io_reset  <= io_reset_n;
         dly_reset <= dly_reset_n;
         ce        <= ce_n;
         bitslip   <= bitslip_n;
         busy      <= busy_n;
         locked    <= locked_n;
         fail      <= fail_n;
         fail_lane <= fail_lane_n;
      end
   end

   // Next-state, counters and next output values
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      match_n     = match_cnt;
      slip_n      = slip_cnt;
      lane_n      = lane;
      tap_0_n     = tap_0;
      tap_1_n     = tap_1;
      busy_n      = busy;
      locked_n    = locked;
      fail_n      = fail;
      fail_lane_n = fail_lane;
      io_reset_n  = '0;
      dly_reset_n = '0;
      ce_n        = '0;
      bitslip_n   = '0;
      lane_word   = lane ? bus.adc_bits[11:6]    : bus.adc_bits[5:0];
      lane_pat    = lane ? TRAIN_PATTERN[11:6]   : TRAIN_PATTERN[5:0];
      lane_tap    = lane ? tap_1 : tap_0;
      lane_mask   = lane ? 2'b10 : 2'b01;

      case (state)
         S_IDLE, S_LOCKED, S_FAIL: begin
            if (bus.start) begin
               state_n     = S_RST;
               cnt_n       = '0;
               match_n     = '0;
               slip_n      = '0;
               lane_n      = 1'b0;
               tap_0_n     = '0;
               tap_1_n     = '0;
               busy_n      = 1'b1;
               locked_n    = 1'b0;
               fail_n      = 1'b0;
               fail_lane_n = 1'b0;
               io_reset_n  = 2'b11;
               dly_reset_n = 2'b11;
            end
         end
         S_RST: begin
            if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
               state_n = S_SETTLE;
               cnt_n   = '0;
               match_n = '0;
            end else begin
               cnt_n       = cnt + 1'b1;
               io_reset_n  = 2'b11;
               dly_reset_n = 2'b11;
            end
         end
         S_SETTLE: begin
            if (cnt == CNT_W'(SETTLE - 1)) begin
               state_n = S_CHECK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_CHECK: begin
            if (lane_word == lane_pat) begin
               if (match_cnt == MATCH_W'(MATCH_LEN - 1)) begin
                  match_n = '0;
                  if (!lane) begin
                     lane_n  = 1'b1;
                     slip_n  = '0;
                     cnt_n   = '0;
                     state_n = S_SETTLE;
                  end else begin
                     state_n  = S_LOCKED;
                     locked_n = 1'b1;
                     busy_n   = 1'b0;
                  end
               end else begin
                  match_n = match_cnt + 1'b1;
               end
            end else begin
               match_n   = '0;
               state_n   = S_SLIP;
               bitslip_n = lane_mask;
            end
         end
         // The sixth slip restores the original alignment, already checked, so step the delay instead
         S_SLIP: begin
            cnt_n = '0;
            if (slip_cnt == SLIP_W'(SLIPS_PER_TAP - 1)) begin
               slip_n  = '0;
               state_n = S_STEP;
               if (lane_tap != TAP_W'(MAX_TAP)) begin
                  ce_n = lane_mask;
               end
            end else begin
               slip_n  = slip_cnt + 1'b1;
               state_n = S_SETTLE;
            end
         end
         S_STEP: begin
            slip_n = '0;
            if (lane_tap == TAP_W'(MAX_TAP)) begin
               state_n     = S_FAIL;
               fail_n      = 1'b1;
               fail_lane_n = lane;
               busy_n      = 1'b0;
            end else begin
               if (lane) tap_1_n = tap_1 + 1'b1;
               else      tap_0_n = tap_0 + 1'b1;
               cnt_n   = '0;
               state_n = S_SETTLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.adc_io_reset      = io_reset;
   assign bus.in_delay_reset    = dly_reset;
   assign bus.in_delay_data_ce  = ce;
   assign bus.in_delay_data_inc = 2'b11;
   assign bus.adc_bitslip       = bitslip;
   assign bus.busy              = busy;
   assign bus.locked            = locked;
   assign bus.fail              = fail;
   assign bus.fail_lane         = fail_lane;
   assign bus.tap_0             = tap_0;
   assign bus.tap_1             = tap_1;

endmodule

// File: tb/tb_adc_lane_align_ctrl.sv
// Directed bench for adc_lane_align_ctrl with a behavioural two-lane channel model.
module tb_adc_lane_align_ctrl;

   logic clk = 1'b0;
   logic rst;
   adc_lane_align_ctrl_if bus ();

   adc_lane_align_ctrl dut (.lclk(clk), .rst(rst), .bus(bus.master));

   always #5 clk = ~clk;

   // Lane slices of 12'hB38
   localparam logic [5:0] PAT0 = 6'h38;
   localparam logic [5:0] PAT1 = 6'h2C;

   int   mode [2];
   int   rot  [2];
   logic ign_slip;
   logic corrupt;

   int m_slips [2];
   int m_tap   [2];
   int slip_pulses [2];
   int ce_pulses   [2];
   int iorst_cyc, dlyrst_cyc, gap_viol, both_cyc, cyc;
   int last_slip = -100;

   int n_pass = 0;
   int n_total = 0;

   // Channel word for one lane given slips seen and current delay tap
   function automatic logic [5:0] lane_word(input logic [5:0] pat, input int md, input int r,
                                            input int slips, input int tap, input logic ign);
      int eff;
      int sh;
      logic [5:0] v;
      eff = ign ? 0 : slips;
      v   = pat;
      sh  = 0;
      case (md)
         0: sh = (r + 6 - (eff % 6)) % 6;
         1: sh = (6 - (eff % 6)) % 6;
         default: sh = 0;
      endcase
      for (int i = 0; i < sh; i++) v = {v[4:0], v[5]};
      if (md == 2 || (md == 1 && tap != 2)) v = 6'h00;
      return v;
   endfunction

   always_comb begin
      bus.adc_bits = {lane_word(PAT1, mode[1], rot[1], m_slips[1], m_tap[1], ign_slip),
                      lane_word(PAT0, mode[0], rot[0], m_slips[0], m_tap[0], ign_slip)
                      ^ (corrupt ? 6'h01 : 6'h00)};
   end

   // Channel state and event counters
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.adc_io_reset != 2'b00)   iorst_cyc  <= iorst_cyc + 1;
      if (bus.in_delay_reset != 2'b00) dlyrst_cyc <= dlyrst_cyc + 1;
      if (bus.locked && bus.fail)      both_cyc   <= both_cyc + 1;
      if (bus.adc_bitslip != 2'b00) begin
         if (cyc - last_slip < 5) gap_viol <= gap_viol + 1;
         last_slip <= cyc;
      end
      for (int i = 0; i < 2; i++) begin
         if (bus.adc_io_reset[i])          m_slips[i] <= 0;
         else if (bus.adc_bitslip[i])      m_slips[i] <= m_slips[i] + 1;
         if (bus.in_delay_reset[i])        m_tap[i]   <= 0;
         else if (bus.in_delay_data_ce[i]) m_tap[i]   <= m_tap[i] + 1;
         if (bus.adc_bitslip[i])      slip_pulses[i] <= slip_pulses[i] + 1;
         if (bus.in_delay_data_ce[i]) ce_pulses[i]   <= ce_pulses[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Pulse start, then wait for locked/fail; optional extra start pulse and corrupted word
   task automatic run_train(input string tag, input int budget, input int start_at,
                            input int corrupt_at, output int n);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      n = 0;
      while (!(bus.locked || bus.fail) && n < budget) begin
         corrupt   = (n == corrupt_at);
         bus.start = (n == start_at);
         @(posedge clk); #1;
         n++;
      end
      bus.start = 1'b0;
      corrupt   = 1'b0;
      chk({tag, "_done"}, 32'(bus.locked || bus.fail), 32'd1);
   endtask

   int n;
   int s0, s1, c0, c1, io0, dl0, g0;

   task automatic snap();
      s0 = slip_pulses[0]; s1 = slip_pulses[1];
      c0 = ce_pulses[0];   c1 = ce_pulses[1];
      io0 = iorst_cyc;     dl0 = dlyrst_cyc;  g0 = gap_viol;
   endtask

   initial begin
      cyc = 0; iorst_cyc = 0; dlyrst_cyc = 0; gap_viol = 0; both_cyc = 0;
      for (int i = 0; i < 2; i++) begin
         m_slips[i] = 0; m_tap[i] = 0; slip_pulses[i] = 0; ce_pulses[i] = 0;
         mode[i] = 0; rot[i] = 0;
      end
      ign_slip = 1'b0; corrupt = 1'b0;
      rst = 1'b1; bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_io_reset", 32'(bus.adc_io_reset), 32'd0);
      chk("rst_dly_reset", 32'(bus.in_delay_reset), 32'd0);
      chk("rst_ce", 32'(bus.in_delay_data_ce), 32'd0);
      chk("rst_inc", 32'(bus.in_delay_data_inc), 32'd3);
      chk("rst_bitslip", 32'(bus.adc_bitslip), 32'd0);
      chk("rst_flags", {29'd0, bus.busy, bus.locked, bus.fail}, 32'd0);
      chk("rst_taps", {22'd0, bus.tap_1, bus.tap_0}, 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("idle_no_start_busy", 32'(bus.busy), 32'd0);

      // Aligned lanes; extra start in CHECK must be ignored
      snap();
      run_train("aligned", 200, 20, -1, n);
      chk("aligned_latency", 32'(n), 32'd48);
      chk("aligned_locked", {30'd0, bus.locked, bus.fail}, 32'd2);
      chk("aligned_busy", 32'(bus.busy), 32'd0);
      chk("aligned_taps", {22'd0, bus.tap_1, bus.tap_0}, 32'd0);
      chk("aligned_slips", 32'(slip_pulses[0] - s0 + slip_pulses[1] - s1), 32'd0);
      chk("aligned_ce", 32'(ce_pulses[0] - c0 + ce_pulses[1] - c1), 32'd0);
      chk("aligned_io_reset_len", 32'(iorst_cyc - io0), 32'd8);
      chk("aligned_dly_reset_len", 32'(dlyrst_cyc - dl0), 32'd8);

      // Rotated lanes: 3 slips on lane 0, then 5 on lane 1
      rot[0] = 3; rot[1] = 5;
      snap();
      run_train("rot", 2000, -1, -1, n);
      chk("rot_locked", {30'd0, bus.locked, bus.fail}, 32'd2);
      chk("rot_slips0", 32'(slip_pulses[0] - s0), 32'd3);
      chk("rot_slips1", 32'(slip_pulses[1] - s1), 32'd5);
      chk("rot_ce", 32'(ce_pulses[0] - c0 + ce_pulses[1] - c1), 32'd0);
      chk("rot_slip_gap", 32'(gap_viol - g0), 32'd0);
      chk("rot_inc", 32'(bus.in_delay_data_inc), 32'd3);

      // Lane 1 aligns only at delay tap 2
      rot[0] = 0; rot[1] = 0; mode[1] = 1;
      snap();
      run_train("tap2", 3000, -1, -1, n);
      chk("tap2_locked", {30'd0, bus.locked, bus.fail}, 32'd2);
      chk("tap2_slips0", 32'(slip_pulses[0] - s0), 32'd0);
      chk("tap2_slips1", 32'(slip_pulses[1] - s1), 32'd12);
      chk("tap2_ce1", 32'(ce_pulses[1] - c1), 32'd2);
      chk("tap2_ce0", 32'(ce_pulses[0] - c0), 32'd0);
      chk("tap2_taps", {22'd0, bus.tap_1, bus.tap_0}, {22'd0, 5'd2, 5'd0});

      // One corrupted word after 15 matches: one slip, match count restarts
      mode[1] = 0; ign_slip = 1'b1;
      snap();
      run_train("corrupt", 300, -1, 27, n);
      chk("corrupt_latency", 32'(n), 32'd69);
      chk("corrupt_locked", {30'd0, bus.locked, bus.fail}, 32'd2);
      chk("corrupt_slips0", 32'(slip_pulses[0] - s0), 32'd1);
      chk("corrupt_ce", 32'(ce_pulses[0] - c0 + ce_pulses[1] - c1), 32'd0);
      ign_slip = 1'b0;

      // Lane 0 never matches: exhaust all taps
      mode[0] = 2;
      snap();
      run_train("fail", 4000, -1, -1, n);
      chk("fail_flags", {30'd0, bus.locked, bus.fail}, 32'd1);
      chk("fail_lane", 32'(bus.fail_lane), 32'd0);
      chk("fail_busy", 32'(bus.busy), 32'd0);
      chk("fail_tap0", 32'(bus.tap_0), 32'd31);
      chk("fail_slips0", 32'(slip_pulses[0] - s0), 32'd192);
      chk("fail_ce0", 32'(ce_pulses[0] - c0), 32'd31);
      chk("fail_slips1", 32'(slip_pulses[1] - s1), 32'd0);
      repeat (3) @(posedge clk);
      #1 chk("fail_held", 32'(bus.fail), 32'd1);

      // rst while in RST
      mode[0] = 0;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      chk("rstrst_fail_cleared", 32'(bus.fail), 32'd0);
      repeat (2) @(posedge clk);
      #1 chk("rstrst_in_rst", 32'(bus.adc_io_reset), 32'd3);
      rst = 1'b1;
      #1;
      chk("rstrst_io_reset", 32'(bus.adc_io_reset), 32'd0);
      chk("rstrst_dly_reset", 32'(bus.in_delay_reset), 32'd0);
      chk("rstrst_busy", 32'(bus.busy), 32'd0);
      #2 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("rstrst_stays_idle", {29'd0, bus.busy, bus.adc_io_reset}, 32'd0);

      // rst while a bitslip pulse is out
      rot[0] = 3;
      snap();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      n = 0;
      while (bus.adc_bitslip[0] !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rstslip_reached", 32'(bus.adc_bitslip), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstslip_bitslip", 32'(bus.adc_bitslip), 32'd0);
      chk("rstslip_flags", {29'd0, bus.busy, bus.locked, bus.fail}, 32'd0);
      chk("rstslip_inc", 32'(bus.in_delay_data_inc), 32'd3);
      #2 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("rstslip_dropped", 32'(slip_pulses[0] - s0), 32'd0);
      chk("rstslip_idle", 32'(bus.busy), 32'd0);
      chk("never_locked_and_fail", 32'(both_cyc), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
